key_scheduler: RTL and testbench
================================

KEY_SCHEDULER -- requirements
Module: key_scheduler

Interface
REQ-001 clk  input  1  single clock; all state changes on its rising edge.
REQ-002 rst_n  input  1  reset, asynchronous and active-low.
REQ-003 start  input  1  request expansion of key_in; accepted only when busy=0.
REQ-004 key_in  input  128 [0:127]  AES-128 cipher key, bit 0 = MSB of byte 0; sampled only on an accepted start.
REQ-005 busy  output  1  expansion in progress.
REQ-006 rk_valid  output  1  one-cycle strobe: rk_out/rk_round hold a new round key.
REQ-007 rk_round  output  4  index 0..10 of the round key on rk_out.
REQ-008 rk_out  output  128 [0:127]  round key as words w[4r]..w[4r+3], w[4r] in bits 0:31.
REQ-009 done  output  1  one-cycle strobe coincident with the round-10 rk_valid.

Function
REQ-010 The block SHALL implement the FIPS-197 AES-128 key expansion (Nk=4, Nr=10, 44 words), generating one word per clock.
REQ-011 FSM states SHALL be IDLE and EXPAND; IDLE->EXPAND on accepted start; EXPAND->IDLE on the edge that writes w43.
REQ-012 On an accepted start edge (E0), the block SHALL load key_in into the 4-word window and set word index i=4 and Rcon=0x01. In the following cycle it SHALL present rk_valid=1, rk_round=0, rk_out=key_in and busy=1.
REQ-013 On each edge Ek (k=1..40) the block SHALL compute w[i]=w[i-4]^temp, with i=k+3, and then increment i.
REQ-014 temp SHALL be SubWord(RotWord(w[i-1]))^{Rcon,24'h0} when i mod 4 = 0, and w[i-1] otherwise. RotWord moves byte 0 to byte 3.
REQ-015 SubWord SHALL be one shared subword instance; it is combinational, so it adds no latency.
REQ-016 Rcon SHALL step 01,02,04,08,10,20,40,80,1B,36, advancing after each use: xtime, i.e. shift left with conditional ^0x1B.
REQ-017 After edge E(4r), r=1..10, the block SHALL assert rk_valid=1 for exactly one cycle with rk_round=r and rk_out=w[4r..4r+3].
REQ-018 After E40 the block SHALL be in IDLE with busy=0, done=1, rk_valid=1 and rk_round=10. Total latency from start to done is 41 cycles.
REQ-019 start while busy=1 SHALL be ignored; key_in changes during EXPAND SHALL have no effect.
REQ-020 start asserted in the done cycle SHALL be accepted (IDLE), so back-to-back expansions occur with no dead cycle.
REQ-021 rk_out and rk_round SHALL hold their last values between strobes.

Reset
REQ-022 rst_n=0 SHALL asynchronously force IDLE and clear busy, done, rk_valid, rk_round, rk_out, the word window, the index and Rcon (Rcon to 0x01), including mid-expansion.
REQ-023 After reset release, no output SHALL change until an accepted start.

Structure
REQ-024 A shared package/include SHALL hold the FSM state encodings, the constants NK=4, NR=10 and TOTAL_WORDS=44, the Rcon initial value 0x01 and the reduction constant 0x1B.
REQ-025 The only sub-module SHALL be the existing subword (four Sbox lanes). No other hierarchy is used.
REQ-026 Storage SHALL be a 4-word sliding window plus a 128-bit rk_out register; the full 44-word schedule is not stored.

Verification
REQ-027 key_in=2b7e151628aed2a6abf7158809cf4f3c, start pulse -> round1=a0fafe1788542cb123a339392a6c7605, round10=d014f9a8c9ee2589e13f0cc8b6630ca6, done 41 cycles after start edge.
REQ-028 key_in=0 -> round1=62636363626363636263636362636363, round10=b4ef5bcb3e92e21123e951cf6f8f188e.
REQ-029 start pulsed with a different key at cycle 15 of an expansion -> ignored; the output sequence is identical to REQ-027.
REQ-030 rst_n low for 1 cycle at cycle 20 -> all outputs 0 immediately and busy=0. A new start then reproduces REQ-027 exactly.
REQ-031 start held high continuously with alternating keys -> a second run is accepted in each done cycle, and each run matches its golden vectors.
REQ-032 Every run -> exactly 11 rk_valid strobes with rk_round 0..10 in order, and exactly one done.

Source files
------------

// File: rtl/key_scheduler_pkg.sv
// Shared definitions for the AES-128 key scheduler: FSM encoding, schedule
// geometry, Rcon constants and small word helpers.
package key_scheduler_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        EXPAND = 1'b1
    } state_e;

    localparam int NK          = 4;
    localparam int NR          = 10;
    localparam int TOTAL_WORDS = NK * (NR + 1);
    localparam int IDX_W       = 6;

    localparam logic [7:0] RCON_INIT = 8'h01;
    localparam logic [7:0] RCON_RED  = 8'h1B;

    // GF(2^8) multiply by x, reduced by the AES polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_RED : 8'h00);
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/key_scheduler_subword.sv
// SubWord: four parallel AES S-box lanes, purely combinational.
module key_scheduler_subword (
    input  logic [31:0] word_i,
    output logic [31:0] word_o
);

    // Byte n of the table sits in bits [2047-8n -: 8].
    localparam logic [2047:0] SBOX_TAB = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        logic [10:0] pos;
        pos = {~b, 3'b000};
        return SBOX_TAB[pos +: 8];
    endfunction

    assign word_o[31:24] = sbox(word_i[31:24]);
    assign word_o[23:16] = sbox(word_i[23:16]);
    assign word_o[15:8]  = sbox(word_i[15:8]);
    assign word_o[7:0]   = sbox(word_i[7:0]);

endmodule

// File: rtl/key_scheduler.sv
// AES-128 key expansion, one word per clock over a 4-word sliding window;
// each completed group of four words is published as a round key.
module key_scheduler
    import key_scheduler_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         busy,
    output logic         rk_valid,
    output logic [3:0]   rk_round,
    output logic [127:0] rk_out,
    output logic         done
);

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(TOTAL_WORDS - 1);
    localparam logic [IDX_W-1:0] FIRST_IDX = IDX_W'(NK);

    state_e             state_q, state_d;
    logic [31:0]        w_q [NK];
    logic [31:0]        w_d [NK];
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [7:0]         rcon_q, rcon_d;
    logic               rk_valid_q, rk_valid_d;
    logic               done_q, done_d;
    logic [3:0]         rk_round_q, rk_round_d;
    logic [127:0]       rk_out_q, rk_out_d;

    logic               start_ok;
    logic               last_word;
    logic [31:0]        sub_word;
    logic [31:0]        temp;
    logic [31:0]        new_word;

    assign start_ok  = start && (state_q == IDLE);
    assign last_word = (state_q == EXPAND) && (idx_q == LAST_IDX);

    key_scheduler_subword u_subword (
        .word_i (rot_word(w_q[NK-1])),
        .word_o (sub_word)
    );

    // w_q[0] is w[i-4], w_q[3] is w[i-1]; i mod 4 == 0 starts a new round.
    assign temp     = (idx_q[1:0] == 2'b00) ? (sub_word ^ {rcon_q, 24'h0}) : w_q[NK-1];
    assign new_word = w_q[0] ^ temp;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = EXPAND;
            EXPAND:  if (idx_q == LAST_IDX) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == EXPAND);
    end

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        for (int j = 0; j < NK; j++) w_d[j] = w_q[j];
        idx_d      = idx_q;
        rcon_d     = rcon_q;
        rk_valid_d = 1'b0;
        done_d     = 1'b0;
        rk_round_d = rk_round_q;
        rk_out_d   = rk_out_q;

        if (start_ok) begin
            w_d[0]     = key_in[127:96];
            w_d[1]     = key_in[95:64];
            w_d[2]     = key_in[63:32];
            w_d[3]     = key_in[31:0];
            idx_d      = FIRST_IDX;
            rcon_d     = RCON_INIT;
            rk_valid_d = 1'b1;
            rk_round_d = 4'd0;
            rk_out_d   = key_in;
        end else if (state_q == EXPAND) begin
            w_d[0] = w_q[1];
            w_d[1] = w_q[2];
            w_d[2] = w_q[3];
            w_d[3] = new_word;
            idx_d  = idx_q + 1'b1;
            if (idx_q[1:0] == 2'b00) rcon_d = xtime(rcon_q);
            // Writing w[4r+3] completes round key r.
            if (idx_q[1:0] == 2'b11) begin
                rk_valid_d = 1'b1;
                rk_round_d = idx_q[5:2];
                rk_out_d   = {w_q[1], w_q[2], w_q[3], new_word};
            end
            done_d = last_word;
        end
    end

    // NOTE: the 4-entry window is small and architecturally visible, so it is
    // cleared on reset along with everything else.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int j = 0; j < NK; j++) w_q[j] <= '0;
            idx_q      <= '0;
            rcon_q     <= RCON_INIT;
            rk_valid_q <= 1'b0;
            done_q     <= 1'b0;
            rk_round_q <= '0;
            rk_out_q   <= '0;
        end else begin
            for (int j = 0; j < NK; j++) w_q[j] <= w_d[j];
            idx_q      <= idx_d;
            rcon_q     <= rcon_d;
            rk_valid_q <= rk_valid_d;
            done_q     <= done_d;
            rk_round_q <= rk_round_d;
            rk_out_q   <= rk_out_d;
        end
    end

    assign rk_valid = rk_valid_q;
    assign done     = done_q;
    assign rk_round = rk_round_q;
    assign rk_out   = rk_out_q;

endmodule

// File: tb/tb_key_scheduler.sv
// Scoreboard bench for key_scheduler: stimulus pushes expected round keys,
// a negedge monitor pops and compares on every rk_valid strobe.
module tb_key_scheduler;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [127:0] key_in = '0;
    logic         busy;
    logic         rk_valid;
    logic [3:0]   rk_round;
    logic [127:0] rk_out;
    logic         done;

    key_scheduler dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .key_in   (key_in),
        .busy     (busy),
        .rk_valid (rk_valid),
        .rk_round (rk_round),
        .rk_out   (rk_out),
        .done     (done)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] A_R1   = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] A_R10  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] KEY_Z  = 128'h0;
    localparam logic [127:0] Z_R1   = 128'h62636363626363636263636362636363;
    localparam logic [127:0] Z_R10  = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    typedef struct {
        logic [3:0]   round;
        logic [127:0] key;
        logic         chk_key;
        logic         done;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec    = 0;
    int   n_bad    = 0;
    int   n_done   = 0;
    int   exp_runs = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic push_run(input logic [127:0] k, input logic [127:0] r1, input logic [127:0] r10);
        for (int r = 0; r <= 10; r++) begin
            exp_t e;
            e.round   = 4'(r);
            e.done    = (r == 10);
            e.chk_key = (r <= 1) || (r == 10);
            e.key     = (r == 0) ? k : ((r == 1) ? r1 : r10);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (done) begin
                n_done++;
                check("done_with_valid", rk_valid, 1'b1);
            end
            if (rk_valid) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_strobe: got round %0d, expected no strobe", rk_round);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check($sformatf("r%0d_round", e.round), rk_round, e.round);
                    check($sformatf("r%0d_done", e.round), done, e.done);
                    if (e.chk_key) check($sformatf("r%0d_key", e.round), rk_out, e.key);
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Waits for done with a cycle budget; c0 is the current cycle number,
    // counting the cycle in which start was sampled as cycle 0.
    task automatic wait_done(input int c0);
        int cyc;
        cyc = c0;
        while (!done && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency", cyc, 41);
        check("busy_in_done", busy, 1'b0);
        if (done) exp_runs++;
    endtask

    // Issues one start (edge E0) and waits for its done; key_in is scrambled
    // during the expansion and start may be kept high for chaining.
    task automatic run_key(input logic [127:0] k, input logic [127:0] r1,
                           input logic [127:0] r10, input logic keep_start);
        start  = 1'b1;
        key_in = k;
        push_run(k, r1, r10);
        @(posedge clk);
        #1;
        if (!keep_start) start = 1'b0;
        key_in = ~k;
        check("busy_after_start", busy, 1'b1);
        wait_done(1);
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"},     busy, 1'b0);
        check({tag, "_rk_valid"}, rk_valid, 1'b0);
        check({tag, "_done"},     done, 1'b0);
        check({tag, "_rk_round"}, rk_round, 4'd0);
        check({tag, "_rk_out"},   rk_out, 128'h0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then confirm nothing moves without a start.
        cycles(2);
        check_idle_zero("reset");
        rst_n = 1'b1;
        cycles(3);
        check_idle_zero("post_reset");

        // Golden key from the standard, then hold-between-strobes checks.
        run_key(KEY_A, A_R1, A_R10, 1'b0);
        cycles(3);
        check("hold_rk_out", rk_out, A_R10);
        check("hold_rk_round", rk_round, 4'd10);

        // All-zero key.
        run_key(KEY_Z, Z_R1, Z_R10, 1'b0);

        // A start with a different key at cycle 15 must be ignored.
        start  = 1'b1;
        key_in = KEY_A;
        push_run(KEY_A, A_R1, A_R10);
        @(posedge clk);
        #1;
        start  = 1'b0;
        key_in = 128'h0123456789abcdef0123456789abcdef;
        cycles(14);
        start  = 1'b1;
        key_in = KEY_Z;
        cycles(1);
        start  = 1'b0;
        check("round0_held_mid_run", rk_out !== KEY_A, 1'b1);
        wait_done(16);

        // Asynchronous reset at cycle 20 of an expansion.
        cycles(2);
        start  = 1'b1;
        key_in = KEY_A;
        push_run(KEY_A, A_R1, A_R10);
        @(posedge clk);
        #1;
        start  = 1'b0;
        cycles(19);
        rst_n = 1'b0;
        #1;
        check_idle_zero("mid_reset");
        exp_q.delete();
        cycles(1);
        rst_n = 1'b1;
        cycles(4);
        check_idle_zero("after_mid_reset");
        run_key(KEY_A, A_R1, A_R10, 1'b0);

        // start held high with alternating keys: each run begins in the
        // previous run's done cycle.
        cycles(2);
        run_key(KEY_A, A_R1, A_R10, 1'b1);
        run_key(KEY_Z, Z_R1, Z_R10, 1'b1);
        run_key(KEY_A, A_R1, A_R10, 1'b1);
        start = 1'b0;
        cycles(4);
        check("chain_idle_busy", busy, 1'b0);

        check("queue_drained", exp_q.size(), 0);
        check("done_count", n_done, exp_runs);
        check("run_count", exp_runs, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
